byte_load_sequencer: RTL and testbench

- Upstream stage for the 32-bit general register. Fetches 1, 2 or 4 bytes from an 8-bit, fixed-latency memory port and assembles them big-endian into the downstream register.
- Assembly uses only the register's FunSel/E/I controls: one load-low-byte, then shift-in-byte operations.
- Sits between the memory interface and the register file; the control unit starts it with a single-cycle request.

---
 rtl/byte_load_sequencer.sv | 171 +++++++++++++++++
 tb/tb_byte_load_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_load_sequencer.sv
// byte_load_sequencer
// Fetches 1, 2 or 4 bytes from a fixed-latency 8-bit memory port and assembles
// them big-endian into the downstream 32-bit register. The register is driven
// only through its FunSel/E/I controls: one load-low-byte, then shift-in-byte.
//
// Optional feature, enabled by defining the macro SIGN_EXT_EN:
//   adds the Signed input; a signed halfword receives one extra WRITE cycle
//   (FunSel 111) that sign-extends the assembled 16-bit value.
//
// Handshake: Start is a single-cycle request, sampled only in IDLE together
// with Addr, Size (and Signed). Busy is high from the first REQ cycle through
// the DONE cycle; Start while Busy, or in the DONE cycle, is dropped. Done is
// a one-cycle pulse and Err is valid only while Done is high.
module byte_load_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [1:0]        Size,
`ifdef SIGN_EXT_EN
    input  logic              Signed,
`endif
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [7:0]        MemData,
    output logic [31:0]       RegI,
    output logic [2:0]        RegFunSel,
    output logic              RegE
);

    localparam int WCW = $clog2(MEM_LATENCY + 1);

    localparam logic [2:0] FS_LOAD_LOW  = 3'b100;
    localparam logic [2:0] FS_SHIFT_IN  = 3'b110;
    localparam logic [2:0] FS_SIGN_EXT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic [WCW-1:0]    wcnt;
    logic [15:0]       acc16;      // last two bytes fetched, for the sign-extend write
    logic              sext_pend;  // an extra sign-extend WRITE is still owed
    logic [1:0]        next_idx;

    assign next_idx = idx + 2'd1;

    // Sequencer FSM; every output is registered and set on the edge entering its state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            base      <= '0;
            idx       <= '0;
            last_idx  <= '0;
            wcnt      <= '0;
            acc16     <= '0;
            sext_pend <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            MemAddr   <= '0;
            MemRd     <= 1'b0;
            RegI      <= '0;
            RegFunSel <= 3'b000;
            RegE      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    Err  <= 1'b0;
                    RegE <= 1'b0;
                    if (Start) begin
                        base <= Addr;
                        idx  <= 2'd0;
                        Busy <= 1'b1;
`ifdef SIGN_EXT_EN
                        sext_pend <= Signed && (Size == 2'b01);
`else
                        sext_pend <= 1'b0;
`endif
                        case (Size)
                            2'b00:   last_idx <= 2'd0;
                            2'b01:   last_idx <= 2'd1;
                            default: last_idx <= 2'd3;
                        endcase
                        if (Size == 2'b11) begin
                            // Reserved size: report the error without touching memory or register
                            state <= S_DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            MemRd   <= 1'b1;
                            MemAddr <= Addr;
                        end
                    end
                end

                S_REQ: begin
                    MemRd <= 1'b0;
                    wcnt  <= WCW'(MEM_LATENCY - 1);
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (wcnt == '0) begin
                        // MemData is valid on this edge; hand it to the register
                        state     <= S_WRITE;
                        RegE      <= 1'b1;
                        RegI      <= {24'b0, MemData};
                        RegFunSel <= (idx == 2'd0) ? FS_LOAD_LOW : FS_SHIFT_IN;
                        acc16     <= {acc16[7:0], MemData};
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end

                S_WRITE: begin
                    RegE <= 1'b0;
                    if (idx != last_idx) begin
                        idx     <= next_idx;
                        state   <= S_REQ;
                        MemRd   <= 1'b1;
                        MemAddr <= base + ADDR_W'(next_idx);
                    end else if (sext_pend) begin
                        // Stay in WRITE one more cycle to sign-extend the halfword
                        sext_pend <= 1'b0;
                        RegE      <= 1'b1;
                        RegI      <= {16'b0, acc16};
                        RegFunSel <= FS_SIGN_EXT;
                    end else begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                        Err   <= 1'b0;
                    end
                end

                S_DONE: begin
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                    MemRd <= 1'b0;
                    RegE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_load_sequencer.sv
// Directed testbench for byte_load_sequencer (MEM_LATENCY=2, ADDR_W=16).
// Memory is a byte array behind a fixed-latency pipe; the downstream register
// is modelled from the observed RegE/RegFunSel/RegI pulses.
module tb_byte_load_sequencer;

    localparam int L = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] Addr  = '0;
    logic [1:0]  Size  = '0;
    logic        sgn_in = 1'b0;
    logic        Busy, Done, Err, MemRd, RegE;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic [31:0] RegI;
    logic [2:0]  RegFunSel;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    byte_load_sequencer #(.ADDR_W(16), .MEM_LATENCY(L)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Addr      (Addr),
        .Size      (Size),
`ifdef SIGN_EXT_EN
        .Signed    (sgn_in),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err),
        .MemAddr   (MemAddr),
        .MemRd     (MemRd),
        .MemData   (MemData),
        .RegI      (RegI),
        .RegFunSel (RegFunSel),
        .RegE      (RegE)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [65536];
    logic [7:0] pipe [L];

    always @(posedge Clock) begin
        pipe[0] <= MemRd ? mem[MemAddr] : 8'h5A;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign MemData = pipe[L-1];

    // ---------------- monitor + register model ----------------
    logic [31:0] reg_m = '0;
    logic [15:0] addr_q[$];
    logic [2:0]  fs_q[$];
    logic [31:0] regi_q[$];
    logic [15:0] exp_q[$];
    int rd_cnt = 0;
    int we_cnt = 0;

    always @(negedge Clock) begin
        if (MemRd) begin
            rd_cnt++;
            addr_q.push_back(MemAddr);
        end
        if (RegE) begin
            we_cnt++;
            fs_q.push_back(RegFunSel);
            regi_q.push_back(RegI);
            case (RegFunSel)
                3'b100:  reg_m = {24'b0, RegI[7:0]};
                3'b110:  reg_m = {reg_m[23:0], RegI[7:0]};
                3'b111:  reg_m = {{16{RegI[15]}}, RegI[15:0]};
                default: reg_m = 32'hBAD0BAD0;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare the logged MemAddr sequence against exp_q
    task automatic check_addrs(input string tag);
        check({tag, "_rdcnt"}, 32'(addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        addr_q.delete();
        fs_q.delete();
        regi_q.delete();
        exp_q.delete();
        rd_cnt = 0;
        we_cnt = 0;
    endtask

    // ---------------- driver ----------------
    // Pulses Start, then counts cycles until Done. Cycle 1 is the one that
    // follows the edge accepting Start. extra>0 raises a second Start (byte
    // size, other address) for one cycle at that cycle number.
    task automatic run_op(input logic [15:0] a, input logic [1:0] sz, input logic sg,
                          input int extra, output int done_cyc);
        int cyc;
        clear_logs();
        Addr   = a;
        Size   = sz;
        sgn_in = sg;
        Start  = 1'b1;
        @(posedge Clock); #1;
        Start    = 1'b0;
        cyc      = 1;
        done_cyc = -1;
        while (cyc <= 60) begin
            if (Done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == extra) begin
                Start = 1'b1;
                Addr  = 16'h0040;
                Size  = 2'b00;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock); #1;
            cyc++;
        end
        Start = 1'b0;
    endtask

    int dc;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
        mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
        mem[16'h0005] = 8'h9C;
        mem[16'h0020] = 8'h01; mem[16'h0021] = 8'h02;
        mem[16'h0022] = 8'h03; mem[16'h0023] = 8'h04;
        mem[16'h0030] = 8'h80; mem[16'h0031] = 8'h01;

        // Reset state
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy",  32'(Busy), 0);
        check("rst_done",  32'(Done), 0);
        check("rst_err",   32'(Err), 0);
        check("rst_memrd", 32'(MemRd), 0);
        check("rst_maddr", 32'(MemAddr), 0);
        check("rst_rege",  32'(RegE), 0);
        check("rst_fs",    32'(RegFunSel), 0);
        check("rst_regi",  RegI, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // Word read at 0x0010: Done in cycle 4*(2+2)+1 = 17
        run_op(16'h0010, 2'b10, 1'b0, 0, dc);
        check("word_done_cyc", 32'(dc), 17);
        check("word_err", 32'(Err), 0);
        check("word_busy_in_done", 32'(Busy), 1);
        check("word_wecnt", 32'(we_cnt), 4);
        check("word_fs", (fs_q.size() == 4) ? {20'b0, fs_q[0], fs_q[1], fs_q[2], fs_q[3]} : 32'hFFFFFFFF,
              {20'b0, 3'b100, 3'b110, 3'b110, 3'b110});
        check("word_reg", reg_m, 32'h11223344);
        exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        check_addrs("word");
        @(posedge Clock); #1;
        check("word_done_pulse", 32'(Done), 0);
        check("word_busy_after", 32'(Busy), 0);

        // Halfword at 0xFFFF wraps to 0x0000
        run_op(16'hFFFF, 2'b01, 1'b0, 0, dc);
        check("half_done_cyc", 32'(dc), 9);
        check("half_reg", reg_m, 32'h0000ABCD);
        exp_q = '{16'hFFFF, 16'h0000};
        check_addrs("half");
        @(posedge Clock); #1;

        // Byte at 0x0005 replaces a preloaded register value
        reg_m = 32'hDEADBEEF;
        run_op(16'h0005, 2'b00, 1'b0, 0, dc);
        check("byte_done_cyc", 32'(dc), 5);
        check("byte_reg", reg_m, 32'h0000009C);
        check("byte_wecnt", 32'(we_cnt), 1);
        check("byte_fs", (fs_q.size() > 0) ? 32'(fs_q[0]) : 32'hFFFFFFFF, 32'(3'b100));
        exp_q = '{16'h0005};
        check_addrs("byte");
        @(posedge Clock); #1;

        // Reserved size: Done/Err in the first cycle, no memory or register access
        run_op(16'h0010, 2'b11, 1'b0, 0, dc);
        check("rsv_done_cyc", 32'(dc), 1);
        check("rsv_err", 32'(Err), 1);
        @(posedge Clock); #1;
        check("rsv_err_clear", 32'(Err), 0);
        check("rsv_rdcnt", 32'(rd_cnt), 0);
        check("rsv_wecnt", 32'(we_cnt), 0);
        @(posedge Clock); #1;

        // Second Start during a word read is dropped
        run_op(16'h0020, 2'b10, 1'b0, 5, dc);
        check("busy_ign_done_cyc", 32'(dc), 17);
        check("busy_ign_reg", reg_m, 32'h01020304);
        exp_q = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
        check_addrs("busy_ign");
        repeat (4) @(posedge Clock);
        #1;
        check("busy_ign_no_restart", 32'(Busy), 0);

        // Reset in the WAIT after the second byte of a word read
        clear_logs();
        reg_m = '0;
        Addr  = 16'h0010;
        Size  = 2'b10;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("mrst_busy",  32'(Busy), 0);
        check("mrst_memrd", 32'(MemRd), 0);
        check("mrst_maddr", 32'(MemAddr), 0);
        check("mrst_rege",  32'(RegE), 0);
        check("mrst_fs",    32'(RegFunSel), 0);
        check("mrst_regi",  RegI, 0);
        repeat (8) @(posedge Clock);
        #1;
        check("mrst_rdcnt", 32'(rd_cnt), 2);
        check("mrst_wecnt", 32'(we_cnt), 1);
        check("mrst_partial", reg_m, 32'h00000011);

        // Normal operation after the abort
        run_op(16'h0013, 2'b00, 1'b0, 0, dc);
        check("post_rst_done_cyc", 32'(dc), 5);
        check("post_rst_reg", reg_m, 32'h00000044);
        @(posedge Clock); #1;

`ifdef SIGN_EXT_EN
        // Signed halfword: extra sign-extend WRITE, Done one cycle later
        run_op(16'h0030, 2'b01, 1'b1, 0, dc);
        check("sx_done_cyc", 32'(dc), 10);
        check("sx_wecnt", 32'(we_cnt), 3);
        check("sx_last_fs", (fs_q.size() == 3) ? 32'(fs_q[2]) : 32'hFFFFFFFF, 32'(3'b111));
        check("sx_last_regi", (regi_q.size() == 3) ? regi_q[2] : 32'hFFFFFFFF, 32'h00008001);
        check("sx_reg", reg_m, 32'hFFFF8001);
        @(posedge Clock); #1;
        run_op(16'h0030, 2'b01, 1'b0, 0, dc);
        check("ux_done_cyc", 32'(dc), 9);
        check("ux_reg", reg_m, 32'h00008001);
        @(posedge Clock); #1;
`else
        // Without the feature a halfword is always zero-extended
        run_op(16'h0030, 2'b01, 1'b1, 0, dc);
        check("ux_done_cyc", 32'(dc), 9);
        check("ux_reg", reg_m, 32'h00008001);
        @(posedge Clock); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
